uart_mon_rx: RTL and testbench
==============================

Name: uart_mon_rx

Overview:
- Synthesizable 8N1 UART receiver that decodes the SoC's uart0_tx line (fpioa[1]) back into bytes.
- Provides the receiving end of the core's printf/UART path, in the bench and in FPGA loopback builds.
- Received bytes are buffered in a small FIFO and drained through a valid/ready interface.
- Framing errors and overflow are flagged as pulses.

Parameters:
- CLK_DIV, 868: clock cycles per bit (100 MHz / 115200). Legal range 8..65535.
- FIFO_DEPTH, 4: byte FIFO entries. Must be a power of two, 2..16.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- rx_i  input  1  serial line, idle high, asynchronous to clk.
- rx_data_o  output  8  FIFO head byte; valid only while rx_valid_o=1.
- rx_valid_o  output  1  FIFO not empty.
- rx_ready_i  input  1  consumer accept; pop when rx_valid_o & rx_ready_i.
- frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
- overflow_o  output  1  one-cycle pulse: byte received while FIFO full, byte dropped.
- busy_o  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: rx_valid_o=0, rx_data_o=0, frame_err_o=0, overflow_o=0, busy_o=0.
- On reset, FIFO pointers and count are cleared, FSM goes to IDLE and both synchronizer flops are set to 1.
- Reset mid-frame aborts the frame and discards the partial byte. FIFO contents are lost.
- Synchronizer: rx_i passes through 2 flops to give rxs. All decisions use rxs, so the line-to-decision latency is 2 cycles.
- Bit counter: 16-bit cnt, plus a 3-bit bit index.
- FSM states:
  - IDLE: when rxs=0, go to START and load cnt=CLK_DIV/2-1 (integer divide).
  - START: decrement cnt. At cnt=0, if rxs=0, go to DATA with cnt=CLK_DIV-1 and idx=0. If rxs=1 (glitch), go to IDLE with no flags raised.
  - DATA: decrement cnt. At cnt=0, shift rxs into shreg[idx] (LSB first) and reload cnt=CLK_DIV-1. After idx=7, go to STOP; otherwise idx+1.
  - STOP: decrement cnt. At cnt=0 (mid stop bit):
    - rxs=1: push shreg, go to IDLE.
    - rxs=0: pulse frame_err_o next cycle, discard the byte, go to BRK.
  - BRK: wait for rxs=1, then go to IDLE. This prevents a held-low line (break) from retriggering START.
- Push/pop rules:
  - Push happens in the stop-sample cycle. rx_valid_o rises on the next clock edge.
  - rx_data_o is first-word-fall-through: it always shows the head entry.
  - A pop advances the head on the clock edge.
  - Push and pop in the same cycle: both take effect and count is unchanged. This holds even when the FIFO is full; the push is accepted and overflow_o is not raised.
  - Push while full with no pop: byte dropped, overflow_o pulses next cycle, FIFO unchanged.
- Pointer arithmetic: pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally. count is $clog2(FIFO_DEPTH)+1 bits, with full when count==FIFO_DEPTH.
- Sampling point: mid-bit sampling gives ±(CLK_DIV/2 - 1) cycles of tolerance to baud mismatch over the frame.
- No parity and no idle-timeout.
- Back-to-back frames: a start bit immediately following the stop-sample point is accepted. IDLE re-arms in the cycle after STOP.

Test Plan (CLK_DIV=16, FIFO_DEPTH=4 unless noted):
- Byte 0x55 sent at 16 cycles/bit, rx_ready_i=1:
  - rx_valid_o rises for one cycle with rx_data_o=0x55, about 2+8+16*9+1 cycles after the start-bit falling edge.
  - No error pulses.
- Glitch: rx_i low for 5 cycles, then high → FSM returns to IDLE, busy_o drops, no valid and no frame_err.
- Framing error: send 0xA3 with the stop bit held low for 40 cycles:
  - frame_err_o pulses exactly once and nothing is pushed.
  - busy_o stays high until the line returns high.
  - A following 0x3C is received correctly.
- Overflow: rx_ready_i=0, send 0x01..0x05 back to back:
  - After the 4th byte rx_valid_o=1 and the FIFO holds 0x01..0x04.
  - The 5th byte makes overflow_o pulse once.
  - Draining then yields 0x01, 0x02, 0x03, 0x04 in order.
- Full with simultaneous pop: FIFO holds 4 bytes; assert rx_ready_i for exactly the stop-sample cycle of 0x77:
  - No overflow pulse.
  - Drain order is 0x02, 0x03, 0x04, 0x77 (after the popped 0x01).
- Reset mid-frame: assert rst during DATA bit 4 of 0xF0 with 2 bytes queued:
  - All outputs go to 0 immediately (async).
  - After release, sending 0x9E yields exactly one byte 0x9E.

Source files
------------

// File: rtl/uart_mon_rx.sv
// uart_mon_rx: 8N1 UART receiver for the SoC uart0_tx line.
// A two-flop synchronizer feeds a mid-bit sampling FSM. Received bytes go into
// a small first-word-fall-through FIFO that is drained through a valid/ready
// handshake. Framing errors and dropped bytes are reported as one-cycle pulses.
module uart_mon_rx #(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       overflow_o,
  output logic       busy_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Half a bit lands the first sample in the middle of the start bit; every
  // later sample is a whole bit after the previous one.
  localparam logic [15:0] HALF_LOAD = 16'(CLK_DIV / 2 - 1);
  localparam logic [15:0] BIT_LOAD  = 16'(CLK_DIV - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer
  // ---------------------------------------------------------------------------
  logic [1:0] sync_reg;
  logic       rxs;

  // Two-flop synchronizer; reset to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], rx_i};
    end
  end

  assign rxs = sync_reg[1];

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [2:0]  idx_reg, idx_next;
  logic [7:0]  shreg_reg, shreg_next;

  logic        stop_sample;
  logic        push_req;
  logic        ferr_req;

  // State register together with the bit timer, bit index and shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shreg_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shreg_reg <= shreg_next;
    end
  end

  // Next-state logic: count down to each mid-bit point and act there.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    shreg_next = shreg_reg;
    case (state_reg)
      IDLE: begin
        if (!rxs) begin
          state_next = START;
          cnt_next   = HALF_LOAD;
        end
      end
      START: begin
        if (cnt_reg == 16'd0) begin
          if (!rxs) begin
            state_next = DATA;
            cnt_next   = BIT_LOAD;
            idx_next   = 3'd0;
          end else begin
            // Line went back high before mid start bit: treat as a glitch.
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg - 16'd1;
        end
      end
      DATA: begin
        if (cnt_reg == 16'd0) begin
          shreg_next[idx_reg] = rxs;
          cnt_next            = BIT_LOAD;
          if (idx_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end else begin
          cnt_next = cnt_reg - 16'd1;
        end
      end
      STOP: begin
        if (cnt_reg == 16'd0) begin
          // A low stop bit parks in BRK so a held-low line cannot restart.
          state_next = rxs ? IDLE : BRK;
        end else begin
          cnt_next = cnt_reg - 16'd1;
        end
      end
      BRK: begin
        if (rxs) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode: stop-bit sample decides between push and framing error.
  always_comb begin
    stop_sample = (state_reg == STOP) && (cnt_reg == 16'd0);
    push_req    = stop_sample && rxs;
    ferr_req    = stop_sample && !rxs;
    busy_o      = (state_reg != IDLE);
  end

  // ---------------------------------------------------------------------------
  // Byte FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;

  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push_ok;
  logic drop;

  // Handshake decode; a pop frees the slot the same edge, so push into a
  // full FIFO is still accepted when a pop happens alongside it.
  always_comb begin
    fifo_empty = (count_reg == '0);
    fifo_full  = (count_reg == FULL_COUNT);
    pop        = !fifo_empty && rx_ready_i;
    push_ok    = push_req && (!fifo_full || pop);
    drop       = push_req && fifo_full && !pop;
  end

  // Pointer and occupancy update; pointers wrap naturally at FIFO_DEPTH.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push_ok) begin
      wr_ptr_next = wr_ptr_reg + PW'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PW'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // FIFO pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= shreg_reg;
    end
  end

  // Error pulses are registered so they appear the cycle after the stop sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err_o <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      frame_err_o <= ferr_req;
      overflow_o  <= drop;
    end
  end

  assign rx_valid_o = !fifo_empty;
  assign rx_data_o  = fifo_empty ? 8'h00 : mem[rd_ptr_reg];

endmodule

// File: tb/tb_uart_mon_rx.sv
// tb_uart_mon_rx: directed bench for uart_mon_rx (CLK_DIV=16, FIFO_DEPTH=4).
// A timeline model predicts, per clock, what the FIFO holds and when the
// busy/error outputs are active; a per-cycle compare process checks the DUT
// against it, and literal expectations pin the observed byte stream.
module tb_uart_mon_rx;

  localparam int CLK_DIV = 16;
  localparam int DEPTH   = 4;
  // Clock edges from the start-bit falling edge to the stop-sample push edge:
  // 2 sync + 1 idle detect + half bit + 8 data bits + half of... whole stop.
  localparam int FRAME_PUSH = 3 + CLK_DIV / 2 + 9 * CLK_DIV;
  localparam int MAXC = 20000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_i = 1'b1;
  logic       rx_ready_i = 1'b0;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       frame_err_o;
  logic       overflow_o;
  logic       busy_o;

  uart_mon_rx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_i       (rx_i),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .rx_ready_i (rx_ready_i),
    .frame_err_o(frame_err_o),
    .overflow_o (overflow_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Timeline model: per edge index, the byte pushed (-1 none), frame error,
  // busy level; plus the expected FIFO contents as a queue.
  int         push_at [MAXC];
  bit         ferr_at [MAXC];
  bit         busy_at [MAXC];
  logic [7:0] q[$];
  bit         will_pop = 1'b0;

  // Observations of the DUT used by literal expectations.
  logic [7:0] log_q[$];
  int         ferr_seen = 0;
  int         ovf_seen  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare: advance the model by one edge, then check the outputs.
  always @(negedge clk) begin
    bit exp_ovf;
    exp_ovf = 1'b0;
    if (cyc < MAXC) begin
      if (will_pop && q.size() != 0) void'(q.pop_front());
      if (push_at[cyc] >= 0) begin
        if (q.size() < DEPTH) q.push_back(8'(push_at[cyc]));
        else exp_ovf = 1'b1;
      end
      chk("valid", rx_valid_o, q.size() != 0);
      if (q.size() != 0) chk("data", rx_data_o, q[0]);
      chk("overflow", overflow_o, exp_ovf);
      chk("frame_err", frame_err_o, ferr_at[cyc]);
      chk("busy", busy_o, busy_at[cyc]);
      if (frame_err_o) ferr_seen++;
      if (overflow_o) ovf_seen++;
      if (rx_valid_o && rx_ready_i) log_q.push_back(rx_data_o);
      will_pop = rx_ready_i && (q.size() != 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) step();
  endtask

  // Send one frame. stop_low>0 holds the stop bit low that many cycles;
  // pop_stop raises rx_ready_i for the stop-sample cycle only; abort_bit>=0
  // returns halfway through that data bit.
  task automatic send(input logic [7:0] b, input int stop_low, input bit pop_stop,
                      input int abort_bit);
    int e;
    e = cyc;
    if (stop_low == 0) begin
      push_at[e + FRAME_PUSH] = int'(b);
      for (int c = e + 3; c < e + FRAME_PUSH; c++) busy_at[c] = 1'b1;
    end else begin
      ferr_at[e + FRAME_PUSH] = 1'b1;
      for (int c = e + 3; c < e + 9 * CLK_DIV + stop_low + 3; c++) busy_at[c] = 1'b1;
    end
    rx_i = 1'b0;
    repeat (CLK_DIV) step();
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      if (abort_bit == i) begin
        repeat (CLK_DIV / 2) step();
        return;
      end
      repeat (CLK_DIV) step();
    end
    if (stop_low == 0) begin
      rx_i = 1'b1;
      if (pop_stop) begin
        repeat (FRAME_PUSH - 1 - 9 * CLK_DIV) step();
        rx_ready_i = 1'b1;
        step();
        rx_ready_i = 1'b0;
        repeat (CLK_DIV - (FRAME_PUSH - 9 * CLK_DIV)) step();
      end else begin
        repeat (CLK_DIV) step();
      end
    end else begin
      rx_i = 1'b0;
      repeat (stop_low) step();
      rx_i = 1'b1;
    end
  endtask

  task automatic glitch(input int low_cycles);
    int e;
    e = cyc;
    for (int c = e + 3; c < e + 3 + CLK_DIV / 2; c++) busy_at[c] = 1'b1;
    rx_i = 1'b0;
    repeat (low_cycles) step();
    rx_i = 1'b1;
  endtask

  task automatic check_log(input string name, input logic [7:0] exp[$]);
    chk({name, "_count"}, log_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < log_q.size(); i++)
      chk({name, "_byte"}, log_q[i], exp[i]);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_valid"}, rx_valid_o, 1'b0);
    chk({name, "_data"}, rx_data_o, 8'h00);
    chk({name, "_frame_err"}, frame_err_o, 1'b0);
    chk({name, "_overflow"}, overflow_o, 1'b0);
    chk({name, "_busy"}, busy_o, 1'b0);
  endtask

  initial begin
    #(MAXC * 10);
    $display("FAIL watchdog: simulation exceeded %0d cycles", MAXC);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < MAXC; c++) begin
      push_at[c] = -1;
      ferr_at[c] = 1'b0;
      busy_at[c] = 1'b0;
    end

    // Reset values.
    step();
    step();
    check_reset_outputs("reset");
    rst = 1'b0;
    idle(10);

    // Single byte with the consumer always ready.
    rx_ready_i = 1'b1;
    log_q.delete();
    send(8'h55, 0, 1'b0, -1);
    idle(20);
    check_log("byte55", '{8'h55});
    chk("byte55_frame_err_pulses", ferr_seen, 0);
    chk("byte55_overflow_pulses", ovf_seen, 0);

    // Short low glitch must not start a frame.
    log_q.delete();
    glitch(5);
    idle(20);
    check_log("glitch", '{});
    chk("glitch_busy", busy_o, 1'b0);
    chk("glitch_frame_err_pulses", ferr_seen, 0);

    // Framing error with a long low stop bit, then a clean byte.
    send(8'hA3, 40, 1'b0, -1);
    idle(20);
    chk("ferr_pulses", ferr_seen, 1);
    check_log("ferr_nopush", '{});
    send(8'h3C, 0, 1'b0, -1);
    idle(20);
    check_log("after_ferr", '{8'h3C});

    // Overflow: five bytes back to back with nobody draining.
    rx_ready_i = 1'b0;
    log_q.delete();
    ovf_seen = 0;
    for (int i = 1; i <= 5; i++) send(8'(i), 0, 1'b0, -1);
    idle(4);
    chk("ovf_valid", rx_valid_o, 1'b1);
    chk("ovf_pulses", ovf_seen, 1);
    rx_ready_i = 1'b1;
    idle(8);
    rx_ready_i = 1'b0;
    check_log("ovf_drain", '{8'h01, 8'h02, 8'h03, 8'h04});

    // Full FIFO with a pop in the same cycle as the push of 0x77.
    log_q.delete();
    ovf_seen = 0;
    for (int i = 1; i <= 4; i++) send(8'(i), 0, 1'b0, -1);
    send(8'h77, 0, 1'b1, -1);
    idle(4);
    chk("fullpop_ovf_pulses", ovf_seen, 0);
    rx_ready_i = 1'b1;
    idle(10);
    rx_ready_i = 1'b0;
    check_log("fullpop_drain", '{8'h01, 8'h02, 8'h03, 8'h04, 8'h77});

    // Reset in the middle of data bit 4 with two bytes queued.
    send(8'h11, 0, 1'b0, -1);
    send(8'h22, 0, 1'b0, -1);
    send(8'hF0, 0, 1'b0, 4);
    rst = 1'b1;
    rx_i = 1'b1;
    for (int c = cyc; c < MAXC; c++) begin
      push_at[c] = -1;
      ferr_at[c] = 1'b0;
      busy_at[c] = 1'b0;
    end
    q.delete();
    will_pop = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (3) step();
    rst = 1'b0;
    idle(10);
    log_q.delete();
    rx_ready_i = 1'b1;
    send(8'h9E, 0, 1'b0, -1);
    idle(20);
    check_log("after_reset", '{8'h9E});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
